// File: rtl/ringbuffer_ctrl_pkg.sv
// Shared definitions for the ADC ring buffer trigger sequencer: FSM state
// encodings, ring buffer read latency and the dead-time decode.
package ringbuffer_ctrl_pkg;

   localparam logic [3:0] ST_IDLE       = 4'd0;
   localparam logic [3:0] ST_FILL       = 4'd1;
   localparam logic [3:0] ST_ARMED      = 4'd2;
   localparam logic [3:0] ST_POST       = 4'd3;
   localparam logic [3:0] ST_CALC       = 4'd4;
   localparam logic [3:0] ST_HEADER     = 4'd5;
   localparam logic [3:0] ST_RD_SETUP   = 4'd6;
   localparam logic [3:0] ST_RD_FETCH   = 4'd7;
   localparam logic [3:0] ST_RD_PRESENT = 4'd8;

   // Address-to-data latency of the ring buffer read port (RD_SETUP + RD_FETCH).
   localparam int RB_RD_LAT = 2;

   function automatic logic is_busy(input logic [3:0] st);
      return !((st == ST_IDLE) || (st == ST_FILL) || (st == ST_ARMED));
   endfunction

endpackage

// File: rtl/ringbuffer_ctrl_outreg.sv
// Readout holding register: keeps out_data/out_valid/out_last stable while the
// downstream stalls. Sample words pass rb_dout through on their first cycle.
module ringbuffer_ctrl_outreg
   import ringbuffer_ctrl_pkg::*;
#(
   parameter int WIDTH = 14
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             load,
   input  logic             load_last,
   input  logic             hdr_load,
   input  logic [WIDTH-1:0] hdr_data,
   input  logic [WIDTH-1:0] rb_dout,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             out_last
);

   logic             valid_r;
   logic             last_r;
   logic             pass_r;
   logic [WIDTH-1:0] hold_r;
   logic [WIDTH-1:0] data_s;

   // Word load, capture of the pass-through word, and release on handshake.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         valid_r <= 1'b0;
         last_r  <= 1'b0;
         pass_r  <= 1'b0;
         hold_r  <= {WIDTH{1'b0}};
      end else if (load) begin
         valid_r <= 1'b1;
         last_r  <= load_last;
         pass_r  <= 1'b1;
      end else if (hdr_load) begin
         valid_r <= 1'b1;
         last_r  <= 1'b0;
         pass_r  <= 1'b0;
         hold_r  <= hdr_data;
      end else if (valid_r) begin
         if (pass_r) begin
            hold_r <= rb_dout;
            pass_r <= 1'b0;
         end
         if (out_ready) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
         end
      end
   end

   // Output data select; zero whenever no word is on offer.
   always_comb begin
      data_s = {WIDTH{1'b0}};
      if (!valid_r) begin
         data_s = {WIDTH{1'b0}};
      end else if (pass_r) begin
         data_s = rb_dout;
      end else begin
         data_s = hold_r;
      end
   end

   assign out_data  = data_s;
   assign out_valid = valid_r;
   assign out_last  = last_r;

endmodule

// File: rtl/ringbuffer_ctrl.sv
// Trigger-driven ADC ring buffer sequencer: fill, arm, capture a PRE/POST window,
// then read it back oldest-first. Optional event header: RINGBUFFER_CTRL_HEADER_EN.
module ringbuffer_ctrl
   import ringbuffer_ctrl_pkg::*;
#(
   parameter int SIZE  = 10,
   parameter int WIDTH = 14,
   parameter int PRE   = 64,
   parameter int POST  = 192
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             run,
   input  logic             adc_valid,
   input  logic             trig,
   output logic             rb_wr_en,
   output logic             rb_rd_en,
   output logic [SIZE-1:0]  rb_ain,
   input  logic [SIZE-1:0]  rb_aout,
   input  logic [WIDTH-1:0] rb_dout,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy
);

   localparam logic [SIZE:0]   ZERO_C   = {(SIZE+1){1'b0}};
   localparam logic [SIZE:0]   ONE_C    = (SIZE+1)'(1);
   localparam logic [SIZE:0]   PRE_C    = (SIZE+1)'(PRE);
   localparam logic [SIZE:0]   POST_C   = (SIZE+1)'(POST);
   localparam logic [SIZE:0]   N_C      = (SIZE+1)'(PRE + POST);
   // Truncation to SIZE bits makes a full-depth window start at rb_aout itself.
   localparam logic [SIZE-1:0] N_ADDR   = SIZE'(PRE + POST);
   localparam logic [SIZE-1:0] ADDR_ONE = SIZE'(1);

   logic [3:0]       state_r;
   logic [SIZE:0]    fill_cnt_r;
   logic [SIZE:0]    post_cnt_r;
   logic [SIZE:0]    rd_cnt_r;
   logic [SIZE-1:0]  rd_ptr_r;
   logic             wr_s;
   logic             accept_s;
   logic             hdr_load_s;
   logic [WIDTH-1:0] hdr_data_s;

`ifdef RINGBUFFER_CTRL_HEADER_EN
   logic [WIDTH-1:0] evt_cnt_r;
`endif

   assign wr_s     = adc_valid && !rst &&
                     ((state_r == ST_FILL) || (state_r == ST_ARMED) || (state_r == ST_POST));
   assign accept_s = out_valid && out_ready;

   assign rb_wr_en = wr_s;
   assign rb_rd_en = (state_r == ST_RD_FETCH) && !rst;
   assign rb_ain   = rd_ptr_r;
   assign busy     = is_busy(state_r);

   // Sequencer state and window counters.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         fill_cnt_r <= ZERO_C;
         post_cnt_r <= ZERO_C;
         rd_cnt_r   <= ZERO_C;
         rd_ptr_r   <= {SIZE{1'b0}};
`ifdef RINGBUFFER_CTRL_HEADER_EN
         evt_cnt_r  <= {WIDTH{1'b0}};
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               fill_cnt_r <= ZERO_C;
               if (run) begin
                  state_r <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (!run) begin
                  state_r <= ST_IDLE;
               end else if (fill_cnt_r == PRE_C) begin
                  state_r <= ST_ARMED;
               end
               if (wr_s && (fill_cnt_r != PRE_C)) begin
                  fill_cnt_r <= fill_cnt_r + ONE_C;
               end
            end
            ST_ARMED: begin
               if (!run) begin
                  state_r <= ST_IDLE;
               end else if (trig) begin
                  // The trigger-cycle sample is already post sample 1.
                  post_cnt_r <= POST_C - {{SIZE{1'b0}}, adc_valid};
                  state_r    <= ((POST_C == ONE_C) && adc_valid) ? ST_CALC : ST_POST;
`ifdef RINGBUFFER_CTRL_HEADER_EN
                  evt_cnt_r  <= evt_cnt_r + WIDTH'(1);
`endif
               end
            end
            ST_POST: begin
               if (wr_s) begin
                  post_cnt_r <= post_cnt_r - ONE_C;
                  if (post_cnt_r == ONE_C) begin
                     state_r <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               rd_ptr_r <= rb_aout - N_ADDR;
               rd_cnt_r <= N_C;
`ifdef RINGBUFFER_CTRL_HEADER_EN
               state_r  <= ST_HEADER;
`else
               state_r  <= ST_RD_SETUP;
`endif
            end
            ST_HEADER: begin
               if (accept_s) begin
                  state_r <= ST_RD_SETUP;
               end
            end
            ST_RD_SETUP: begin
               state_r <= ST_RD_FETCH;
            end
            ST_RD_FETCH: begin
               state_r <= ST_RD_PRESENT;
            end
            ST_RD_PRESENT: begin
               if (accept_s) begin
                  rd_ptr_r <= rd_ptr_r + ADDR_ONE;
                  rd_cnt_r <= rd_cnt_r - ONE_C;
                  if (rd_cnt_r == ONE_C) begin
                     fill_cnt_r <= ZERO_C;
                     state_r    <= run ? ST_FILL : ST_IDLE;
                  end else begin
                     state_r <= ST_RD_SETUP;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef RINGBUFFER_CTRL_HEADER_EN
   // Header carries the pre-increment event count of the trigger just taken.
   assign hdr_load_s = (state_r == ST_CALC);
   assign hdr_data_s = evt_cnt_r - WIDTH'(1);
`else
   assign hdr_load_s = 1'b0;
   assign hdr_data_s = {WIDTH{1'b0}};
`endif

   ringbuffer_ctrl_outreg #(
      .WIDTH (WIDTH)
   ) u_outreg (
      .sysclk    (sysclk),
      .rst       (rst),
      .load      (state_r == ST_RD_FETCH),
      .load_last (rd_cnt_r == ONE_C),
      .hdr_load  (hdr_load_s),
      .hdr_data  (hdr_data_s),
      .rb_dout   (rb_dout),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last)
   );

endmodule
